apbuart_flat: RTL and testbench

- APB slave UART with flattened APB/UART signals (no record types).
- One-entry TX and RX holding registers, optional parity and CTS/RTS flow control, programmable baud scaler, level-free pulse interrupt.
- Sits on a peripheral APB bus behind the APB bridge; its select bit is psel[PINDEX].

---
 rtl/apbuart_pkg.sv | 36 +++
 rtl/apbuart_baudgen.sv | 66 ++++++
 rtl/apbuart_flat.sv | 309 ++++++++++++++++++++++++++++++
 tb/tb_apbuart_flat.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apbuart_pkg.sv
// Shared register map, bit positions and FSM state types for the flattened APB UART.
package apbuart_pkg;

    localparam int unsigned RegData    = 0;
    localparam int unsigned RegStatus  = 1;
    localparam int unsigned RegControl = 2;
    localparam int unsigned RegScaler  = 3;

    localparam int unsigned StDr = 0;
    localparam int unsigned StTs = 1;
    localparam int unsigned StTe = 2;
    localparam int unsigned StBr = 3;
    localparam int unsigned StOv = 4;
    localparam int unsigned StPe = 5;
    localparam int unsigned StFe = 6;

    localparam int unsigned CtRe  = 0;
    localparam int unsigned CtTe  = 1;
    localparam int unsigned CtRi  = 2;
    localparam int unsigned CtTi  = 3;
    localparam int unsigned CtPs  = 4;
    localparam int unsigned CtPen = 5;
    localparam int unsigned CtFl  = 6;
    localparam int unsigned CtLb  = 7;
    localparam int unsigned CtEc  = 8;
    localparam int unsigned CtrlBits = 9;

    typedef enum logic [2:0] {TxIdle, TxStart, TxData, TxParity, TxStop} tx_state_e;
    typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxParity, RxStop} rx_state_e;

    // odd=1 makes the total count of ones (data + parity) odd
    function automatic logic parity_bit(input logic [7:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/apbuart_baudgen.sv
// Baud scaler: 8x-baud tick from a reloading down-counter, plus the TX bit tick.
module apbuart_baudgen
    import apbuart_pkg::*;
#(
    parameter int unsigned SBITS = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [SBITS-1:0] scaler,
    input  logic             ext_en,
    input  logic             extclk,
    output logic             tick,
    output logic             txtick
);

    logic             ext_s1_q, ext_s2_q, ext_prev_q;
    logic [SBITS-1:0] cnt_q, cnt_d;
    logic [2:0]       txdiv_q, txdiv_d;
    logic             tick_q, tick_d;
    logic             txtick_q, txtick_d;
    logic             step;

    always_comb begin
        step     = ext_en ? (ext_s2_q & ~ext_prev_q) : 1'b1;
        cnt_d    = cnt_q;
        tick_d   = 1'b0;
        txdiv_d  = txdiv_q;
        txtick_d = 1'b0;
        if (step) begin
            if (cnt_q == '0) begin
                cnt_d  = scaler;
                tick_d = 1'b1;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end
        if (tick_q) begin
            txdiv_d  = txdiv_q + 3'd1;
            txtick_d = (txdiv_q == 3'd7);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ext_s1_q   <= 1'b0;
            ext_s2_q   <= 1'b0;
            ext_prev_q <= 1'b0;
            cnt_q      <= '0;
            txdiv_q    <= '0;
            tick_q     <= 1'b0;
            txtick_q   <= 1'b0;
        end else begin
            ext_s1_q   <= extclk;
            ext_s2_q   <= ext_s1_q;
            ext_prev_q <= ext_s2_q;
            cnt_q      <= cnt_d;
            txdiv_q    <= txdiv_d;
            tick_q     <= tick_d;
            txtick_q   <= txtick_d;
        end
    end

    assign tick   = tick_q;
    assign txtick = txtick_q;

endmodule

// File: rtl/apbuart_flat.sv
// APB slave UART with one-entry TX/RX holding registers, optional parity and CTS/RTS flow.
module apbuart_flat
    import apbuart_pkg::*;
#(
    parameter int unsigned PINDEX      = 3,
    parameter logic [11:0] PADDR       = 12'h000,
    parameter logic [11:0] PMASK       = 12'hfff,
    parameter int unsigned CONSOLE     = 0,
    parameter int unsigned PIRQ        = 0,
    parameter int unsigned PARITY      = 1,
    parameter int unsigned FLOW        = 1,
    parameter int unsigned FIFOSIZE    = 1,
    parameter int unsigned ABITS       = 8,
    parameter int unsigned SBITS       = 12,
    parameter int unsigned NAPBSLV     = 16,
    parameter int unsigned NAHBIRQ     = 32,
    parameter int unsigned NTESTINBITS = 4,
    parameter int unsigned NAPBCFG     = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [0:NAPBSLV-1]      psel,
    input  logic                    penable,
    input  logic [31:0]             paddr,
    input  logic                    pwrite,
    input  logic [31:0]             pwdata,
    input  logic [NAHBIRQ-1:0]      pirq_i,
    input  logic                    testen,
    input  logic                    testrst,
    input  logic                    scanen,
    input  logic                    testoen,
    input  logic [NTESTINBITS-1:0]  testin,
    output logic [31:0]             prdata,
    output logic [NAHBIRQ-1:0]      pirq_o,
    output logic [32*NAPBCFG-1:0]   pconfig,
    output logic [31:0]             pindex,
    input  logic                    rxd,
    input  logic                    ctsn,
    input  logic                    extclk,
    output logic                    rtsn,
    output logic                    txd,
    output logic [SBITS-1:0]        scaler,
    output logic                    txen,
    output logic                    rxen,
    output logic                    flow,
    output logic                    txtick,
    output logic                    rxtick
);

    localparam logic [ABITS-3:0] WData    = (ABITS-2)'(RegData);
    localparam logic [ABITS-3:0] WStatus  = (ABITS-2)'(RegStatus);
    localparam logic [ABITS-3:0] WControl = (ABITS-2)'(RegControl);
    localparam logic [ABITS-3:0] WScaler  = (ABITS-2)'(RegScaler);
    localparam logic [CtrlBits-1:0] CtrlMask =
        {2'b11, FLOW != 0, PARITY != 0, PARITY != 0, 4'hF};
    localparam logic [31:0] CfgId  = {8'h01, 12'h00C, 7'd0, 5'(PIRQ)};
    localparam logic [31:0] CfgBar = {PADDR, 4'h0, PMASK, 4'h1};
    localparam logic [63:0] Cfg    = {CfgBar, CfgId};

    logic [CtrlBits-1:0] ctrl_q, ctrl_d;
    logic [SBITS-1:0]    scaler_q, scaler_d;
    logic dr_q, dr_d, ts_q, ts_d, te_q, te_d, br_q, br_d, ov_q, ov_d, pe_q, pe_d, fe_q, fe_d;
    logic [7:0] thold_q, thold_d, rhold_q, rhold_d;
    tx_state_e  tx_state_q, tx_state_d;
    logic [7:0] tshift_q, tshift_d;
    logic [2:0] tbit_q, tbit_d;
    logic       tpar_q, tpar_d, txd_q, txd_d;
    rx_state_e  rx_state_q, rx_state_d;
    logic [7:0] rshift_q, rshift_d;
    logic [2:0] rbit_q, rbit_d, rcnt_q, rcnt_d;
    logic       rperr_q, rperr_d;
    logic       rx_s1_q, rx_s2_q, rx_prev_q, cts_s1_q, cts_s2_q;
    logic       rtsn_q, rtsn_d, irq_q, irq_d, rxtick_q, rxtick_d;

    logic             tick, txtick_int, sel, wr, rd_sel, rx_in, load, frame_done;
    logic [ABITS-3:0] widx;
    logic [31:0]      status;

    apbuart_baudgen #(
        .SBITS (SBITS)
    ) u_baudgen (
        .clk    (clk),
        .rst    (rst),
        .scaler (scaler_q),
        .ext_en (ctrl_q[CtEc]),
        .extclk (extclk),
        .tick   (tick),
        .txtick (txtick_int)
    );

    assign sel    = psel[PINDEX];
    assign widx   = paddr[ABITS-1:2];
    assign wr     = sel & penable & pwrite;
    assign rd_sel = sel & ~pwrite;
    assign rx_in  = ctrl_q[CtLb] ? txd_q : rx_s2_q;
    assign status = {21'b0, dr_q, ~te_q, dr_q, te_q, fe_q, pe_q, ov_q, br_q, te_q, ts_q, dr_q};

    always_comb begin
        prdata = '0;
        if (rd_sel) begin
            case (widx)
                WData:    prdata = {24'b0, rhold_q};
                WStatus:  prdata = status;
                WControl: prdata = {{(32-CtrlBits){1'b0}}, ctrl_q};
                WScaler:  prdata = 32'(scaler_q);
                default:  prdata = '0;
            endcase
        end
    end

    always_comb begin
        ctrl_d = ctrl_q;  scaler_d = scaler_q;
        dr_d = dr_q;  ts_d = ts_q;  te_d = te_q;  br_d = br_q;
        ov_d = ov_q;  pe_d = pe_q;  fe_d = fe_q;
        thold_d = thold_q;  rhold_d = rhold_q;
        tx_state_d = tx_state_q;  tshift_d = tshift_q;  tbit_d = tbit_q;
        tpar_d = tpar_q;  txd_d = txd_q;
        rx_state_d = rx_state_q;  rshift_d = rshift_q;  rbit_d = rbit_q;
        rcnt_d = rcnt_q;  rperr_d = rperr_q;
        load = 1'b0;  frame_done = 1'b0;  rxtick_d = 1'b0;

        unique case (tx_state_q)
            TxIdle: begin
                if (txtick_int && ctrl_q[CtTe] && !te_q && (!ctrl_q[CtFl] || !cts_s2_q)) begin
                    load       = 1'b1;
                    tshift_d   = thold_q;
                    tpar_d     = parity_bit(thold_q, ctrl_q[CtPs]);
                    txd_d      = 1'b0;
                    te_d       = 1'b1;
                    ts_d       = 1'b0;
                    tx_state_d = TxStart;
                end
            end
            TxStart: begin
                if (txtick_int) begin
                    txd_d      = tshift_q[0];
                    tshift_d   = tshift_q >> 1;
                    tbit_d     = 3'd0;
                    tx_state_d = TxData;
                end
            end
            TxData: begin
                if (txtick_int) begin
                    if (tbit_q == 3'd7) begin
                        txd_d      = ctrl_q[CtPen] ? tpar_q : 1'b1;
                        tx_state_d = ctrl_q[CtPen] ? TxParity : TxStop;
                    end else begin
                        txd_d    = tshift_q[0];
                        tshift_d = tshift_q >> 1;
                        tbit_d   = tbit_q + 3'd1;
                    end
                end
            end
            TxParity: begin
                if (txtick_int) begin
                    txd_d      = 1'b1;
                    tx_state_d = TxStop;
                end
            end
            TxStop: begin
                if (txtick_int) begin
                    ts_d       = 1'b1;
                    tx_state_d = TxIdle;
                end
            end
            default: tx_state_d = TxIdle;
        endcase

        // rcnt counts ticks within a bit; start is checked on the 4th, later bits on the 8th
        unique case (rx_state_q)
            RxIdle: begin
                if (ctrl_q[CtRe] && rx_prev_q && !rx_in) begin
                    rcnt_d     = 3'd0;
                    rx_state_d = RxStart;
                end
            end
            RxStart: begin
                if (tick) begin
                    rcnt_d = rcnt_q + 3'd1;
                    if (rcnt_q == 3'd3) begin
                        rxtick_d   = 1'b1;
                        rcnt_d     = 3'd0;
                        rbit_d     = 3'd0;
                        rperr_d    = 1'b0;
                        rx_state_d = rx_in ? RxIdle : RxData;
                    end
                end
            end
            RxData: begin
                if (tick) begin
                    rcnt_d = rcnt_q + 3'd1;
                    if (rcnt_q == 3'd7) begin
                        rxtick_d = 1'b1;
                        rshift_d = {rx_in, rshift_q[7:1]};
                        rbit_d   = rbit_q + 3'd1;
                        if (rbit_q == 3'd7) begin
                            rx_state_d = ctrl_q[CtPen] ? RxParity : RxStop;
                        end
                    end
                end
            end
            RxParity: begin
                if (tick) begin
                    rcnt_d = rcnt_q + 3'd1;
                    if (rcnt_q == 3'd7) begin
                        rxtick_d   = 1'b1;
                        rperr_d    = rx_in ^ parity_bit(rshift_q, ctrl_q[CtPs]);
                        rx_state_d = RxStop;
                    end
                end
            end
            RxStop: begin
                if (tick) begin
                    rcnt_d = rcnt_q + 3'd1;
                    if (rcnt_q == 3'd7) begin
                        rxtick_d   = 1'b1;
                        frame_done = 1'b1;
                        rx_state_d = RxIdle;
                    end
                end
            end
            default: rx_state_d = RxIdle;
        endcase

        if (wr) begin
            case (widx)
                WData: begin
                    thold_d = pwdata[7:0];
                    te_d    = 1'b0;
                end
                WStatus: begin
                    br_d = pwdata[StBr];
                    ov_d = pwdata[StOv];
                    pe_d = pwdata[StPe] & (PARITY != 0);
                    fe_d = pwdata[StFe];
                end
                WControl: ctrl_d = pwdata[CtrlBits-1:0] & CtrlMask;
                WScaler:  scaler_d = pwdata[SBITS-1:0];
                default: ;
            endcase
        end

        if (sel && penable && !pwrite && widx == WData) begin
            dr_d = 1'b0;
        end

        if (frame_done) begin
            if (dr_d) begin
                ov_d = 1'b1;
            end else begin
                rhold_d = rshift_q;
                dr_d    = 1'b1;
            end
            if (!rx_in) begin
                fe_d = 1'b1;
                if (rshift_q == 8'h00) br_d = 1'b1;
            end
            if (rperr_q) pe_d = 1'b1;
        end

        rtsn_d = ~(ctrl_q[CtRe] & ~(ctrl_q[CtFl] & dr_q));
        irq_d  = (frame_done & ctrl_q[CtRi]) | (load & ctrl_q[CtTi]);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctrl_q <= '0;  scaler_q <= '0;
            dr_q <= 1'b0;  ts_q <= 1'b1;  te_q <= 1'b1;  br_q <= 1'b0;
            ov_q <= 1'b0;  pe_q <= 1'b0;  fe_q <= 1'b0;
            thold_q <= '0;  rhold_q <= '0;
            tx_state_q <= TxIdle;  tshift_q <= '0;  tbit_q <= '0;
            tpar_q <= 1'b0;  txd_q <= 1'b1;
            rx_state_q <= RxIdle;  rshift_q <= '0;  rbit_q <= '0;
            rcnt_q <= '0;  rperr_q <= 1'b0;
            rx_s1_q <= 1'b1;  rx_s2_q <= 1'b1;  rx_prev_q <= 1'b1;
            cts_s1_q <= 1'b1;  cts_s2_q <= 1'b1;
            rtsn_q <= 1'b1;  irq_q <= 1'b0;  rxtick_q <= 1'b0;
        end else begin
            ctrl_q <= ctrl_d;  scaler_q <= scaler_d;
            dr_q <= dr_d;  ts_q <= ts_d;  te_q <= te_d;  br_q <= br_d;
            ov_q <= ov_d;  pe_q <= pe_d;  fe_q <= fe_d;
            thold_q <= thold_d;  rhold_q <= rhold_d;
            tx_state_q <= tx_state_d;  tshift_q <= tshift_d;  tbit_q <= tbit_d;
            tpar_q <= tpar_d;  txd_q <= txd_d;
            rx_state_q <= rx_state_d;  rshift_q <= rshift_d;  rbit_q <= rbit_d;
            rcnt_q <= rcnt_d;  rperr_q <= rperr_d;
            rx_s1_q <= rxd;  rx_s2_q <= rx_s1_q;  rx_prev_q <= rx_in;
            cts_s1_q <= ctsn;  cts_s2_q <= cts_s1_q;
            rtsn_q <= rtsn_d;  irq_q <= irq_d;  rxtick_q <= rxtick_d;
        end
    end

    assign txd     = txd_q;
    assign rtsn    = rtsn_q;
    assign scaler  = scaler_q;
    assign txen    = ctrl_q[CtTe];
    assign rxen    = ctrl_q[CtRe];
    assign flow    = ctrl_q[CtFl];
    assign txtick  = txtick_int;
    assign rxtick  = rxtick_q;
    assign pirq_o  = NAHBIRQ'(irq_q) << PIRQ;
    assign pconfig = Cfg[32*NAPBCFG-1:0];
    assign pindex  = 32'(PINDEX);

    logic unused_inputs;
    assign unused_inputs = ^{psel, paddr, pwdata, pirq_i, testen, testrst, scanen, testoen,
                             testin, rbit_q, 32'(CONSOLE), 32'(FIFOSIZE)};

endmodule

// File: tb/tb_apbuart_flat.sv
// Directed self-checking bench for apbuart_flat using a scaler of 1 (16 clocks per bit).
module tb_apbuart_flat;

    localparam int BitClk = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [0:15] psel;
    logic        penable, pwrite;
    logic [31:0] paddr, pwdata, prdata, pindex;
    logic [31:0] pirq_i, pirq_o;
    logic        testen, testrst, scanen, testoen;
    logic [3:0]  testin;
    logic [63:0] pconfig;
    logic        rxd, ctsn, extclk, rtsn, txd;
    logic [11:0] scaler;
    logic        txen, rxen, flow, txtick, rxtick;

    int n_checks = 0;
    int n_fail   = 0;
    int irq_total = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pirq_o[0] === 1'b1) irq_total <= irq_total + 1;
    end

    apbuart_flat dut (
        .clk(clk), .rst(rst), .psel(psel), .penable(penable), .paddr(paddr),
        .pwrite(pwrite), .pwdata(pwdata), .pirq_i(pirq_i), .testen(testen),
        .testrst(testrst), .scanen(scanen), .testoen(testoen), .testin(testin),
        .prdata(prdata), .pirq_o(pirq_o), .pconfig(pconfig), .pindex(pindex),
        .rxd(rxd), .ctsn(ctsn), .extclk(extclk), .rtsn(rtsn), .txd(txd),
        .scaler(scaler), .txen(txen), .rxen(rxen), .flow(flow),
        .txtick(txtick), .rxtick(rxtick)
    );

    task automatic apb_write(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        psel[3] = 1'b1; paddr = addr; pwdata = data; pwrite = 1'b1; penable = 1'b0;
        @(negedge clk);
        penable = 1'b1;
        @(negedge clk);
        psel[3] = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic apb_read(input logic [31:0] addr, output logic [31:0] data);
        @(negedge clk);
        psel[3] = 1'b1; paddr = addr; pwrite = 1'b0; penable = 1'b0;
        @(negedge clk);
        penable = 1'b1;
        #1 data = prdata;
        @(negedge clk);
        psel[3] = 1'b0; penable = 1'b0;
    endtask

    task automatic send_rx(input logic [7:0] d, input bit use_par, input logic par,
                           input logic stop);
        @(negedge clk);
        rxd = 1'b0;
        repeat (BitClk) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = d[i];
            repeat (BitClk) @(negedge clk);
        end
        if (use_par) begin
            rxd = par;
            repeat (BitClk) @(negedge clk);
        end
        rxd = stop;
        repeat (BitClk) @(negedge clk);
        rxd = 1'b1;
        repeat (2 * BitClk) @(negedge clk);
    endtask

    // Waits (bounded) for a start bit on txd, then samples each bit at its middle
    task automatic capture_frame(input int nbits, output logic [11:0] bits, output bit found);
        found = 1'b0;
        bits  = '0;
        for (int i = 0; i < 600 && !found; i++) begin
            @(negedge clk);
            if (txd === 1'b0) found = 1'b1;
        end
        if (found) begin
            repeat (BitClk / 2) @(negedge clk);
            bits[0] = txd;
            for (int i = 1; i < nbits; i++) begin
                repeat (BitClk) @(negedge clk);
                bits[i] = txd;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (4) @(negedge clk);
        n_checks++;
        if (txd !== 1'b1 || rtsn !== 1'b1 || pirq_o !== 32'h0 || txtick !== 1'b0 ||
            rxtick !== 1'b0 || scaler !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_outputs: txd=%b rtsn=%b pirq=%h txtick=%b rxtick=%b scaler=%h",
                     txd, rtsn, pirq_o, txtick, rxtick, scaler);
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        begin
            logic [31:0] r;
            apb_read(32'h4, r);
            n_checks++;
            if (r !== 32'h86) begin
                n_fail++; $display("FAIL reset_status: got %h want %h", r, 32'h86);
            end
            apb_read(32'h8, r);
            n_checks++;
            if (r !== 32'h0) begin
                n_fail++; $display("FAIL reset_control: got %h want %h", r, 32'h0);
            end
        end
        n_checks++;
        if (pindex !== 32'd3) begin
            n_fail++; $display("FAIL pindex: got %0d want 3", pindex);
        end
    endtask

    task automatic test_registers();
        logic [31:0] r;
        apb_write(32'hF, 32'hFF);
        apb_read(32'hC, r);
        n_checks++;
        if (r !== 32'hFF) begin
            n_fail++; $display("FAIL scaler_read: got %h want %h", r, 32'hFF);
        end
        apb_read(32'hF, r);
        n_checks++;
        if (r !== 32'hFF) begin
            n_fail++; $display("FAIL scaler_read_0xF: got %h want %h", r, 32'hFF);
        end
        n_checks++;
        if (scaler !== 12'h0FF) begin
            n_fail++; $display("FAIL scaler_port: got %h want %h", scaler, 12'h0FF);
        end
        apb_read(32'h10, r);
        n_checks++;
        if (r !== 32'h0) begin
            n_fail++; $display("FAIL unmapped_read: got %h want 0", r);
        end
        apb_write(32'h8, 32'h8000_01FF);
        apb_read(32'h8, r);
        n_checks++;
        if (r !== 32'h1FF) begin
            n_fail++; $display("FAIL control_mask: got %h want %h", r, 32'h1FF);
        end
        apb_write(32'h8, 32'h0);
        apb_write(32'hC, 32'h1);
    endtask

    task automatic test_loopback_tx();
        logic [31:0] r;
        logic [11:0] bits;
        bit found;
        apb_write(32'h8, 32'h83);
        apb_write(32'h0, 32'h55);
        capture_frame(10, bits, found);
        n_checks++;
        if (!found || bits[9:0] !== 10'h2AA) begin
            n_fail++; $display("FAIL tx_frame_55: found=%0d got %h want %h", found, bits[9:0], 10'h2AA);
        end
        repeat (40) @(negedge clk);
        apb_read(32'h4, r);
        n_checks++;
        if (r !== 32'h587) begin
            n_fail++; $display("FAIL rx_status_55: got %h want %h", r, 32'h587);
        end
        apb_read(32'h0, r);
        n_checks++;
        if (r !== 32'h55) begin
            n_fail++; $display("FAIL rx_data_55: got %h want %h", r, 32'h55);
        end
        apb_read(32'h4, r);
        n_checks++;
        if (r !== 32'h86) begin
            n_fail++; $display("FAIL dr_clear: got %h want %h", r, 32'h86);
        end
    endtask

    task automatic test_parity();
        logic [31:0] r;
        logic [11:0] bits;
        bit found;
        apb_write(32'h8, 32'hB3);
        apb_write(32'h0, 32'h01);
        capture_frame(11, bits, found);
        n_checks++;
        if (!found || bits[10:0] !== 11'h402) begin
            n_fail++; $display("FAIL tx_frame_odd_par: found=%0d got %h want %h", found, bits[10:0], 11'h402);
        end
        repeat (40) @(negedge clk);
        apb_read(32'h4, r);
        n_checks++;
        if (r !== 32'h587) begin
            n_fail++; $display("FAIL par_ok_status: got %h want %h", r, 32'h587);
        end
        apb_read(32'h0, r);
        n_checks++;
        if (r !== 32'h01) begin
            n_fail++; $display("FAIL par_ok_data: got %h want %h", r, 32'h01);
        end
        apb_write(32'h8, 32'h31);
        send_rx(8'h01, 1'b1, 1'b1, 1'b1);
        apb_read(32'h4, r);
        n_checks++;
        if (r !== 32'h5A7) begin
            n_fail++; $display("FAIL par_err_status: got %h want %h", r, 32'h5A7);
        end
        apb_read(32'h0, r);
        apb_write(32'h4, 32'h0);
        apb_read(32'h4, r);
        n_checks++;
        if (r !== 32'h86) begin
            n_fail++; $display("FAIL status_clear: got %h want %h", r, 32'h86);
        end
    endtask

    task automatic test_overrun();
        logic [31:0] r;
        apb_write(32'h8, 32'h01);
        send_rx(8'h3C, 1'b0, 1'b0, 1'b1);
        send_rx(8'hA5, 1'b0, 1'b0, 1'b1);
        apb_read(32'h4, r);
        n_checks++;
        if (r !== 32'h597) begin
            n_fail++; $display("FAIL overrun_status: got %h want %h", r, 32'h597);
        end
        apb_read(32'h0, r);
        n_checks++;
        if (r !== 32'h3C) begin
            n_fail++; $display("FAIL overrun_data: got %h want %h", r, 32'h3C);
        end
        apb_write(32'h4, 32'h0);
    endtask

    task automatic test_flow_irq();
        logic [31:0] r;
        logic [11:0] bits;
        bit found;
        int zeros;
        int irq_start;
        ctsn = 1'b1;
        apb_write(32'h8, 32'hC7);
        repeat (4) @(negedge clk);
        n_checks++;
        if (rtsn !== 1'b0) begin
            n_fail++; $display("FAIL rtsn_ready: got %b want 0", rtsn);
        end
        apb_write(32'h0, 32'h5A);
        apb_read(32'h4, r);
        n_checks++;
        if (r !== 32'h202) begin
            n_fail++; $display("FAIL hold_full_status: got %h want %h", r, 32'h202);
        end
        zeros = 0;
        for (int i = 0; i < 120; i++) begin
            @(negedge clk);
            if (txd !== 1'b1) zeros++;
        end
        n_checks++;
        if (zeros != 0) begin
            n_fail++; $display("FAIL cts_block: txd low %0d cycles want 0", zeros);
        end
        irq_start = irq_total;
        ctsn = 1'b0;
        capture_frame(10, bits, found);
        n_checks++;
        if (!found || bits[9:0] !== 10'h2B4) begin
            n_fail++; $display("FAIL tx_frame_5A: found=%0d got %h want %h", found, bits[9:0], 10'h2B4);
        end
        repeat (40) @(negedge clk);
        n_checks++;
        if (irq_total - irq_start != 1) begin
            n_fail++; $display("FAIL irq_count: got %0d want 1", irq_total - irq_start);
        end
        n_checks++;
        if (rtsn !== 1'b1) begin
            n_fail++; $display("FAIL rtsn_full: got %b want 1", rtsn);
        end
        apb_read(32'h0, r);
        n_checks++;
        if (r !== 32'h5A) begin
            n_fail++; $display("FAIL flow_rx_data: got %h want %h", r, 32'h5A);
        end
    endtask

    initial begin
        psel = '0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
        pirq_i = '0; testen = 1'b0; testrst = 1'b0; scanen = 1'b0; testoen = 1'b0;
        testin = '0; rxd = 1'b1; ctsn = 1'b0; extclk = 1'b0;
        test_reset();
        test_registers();
        test_loopback_tx();
        test_parity();
        test_overrun();
        test_flow_irq();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
